exec_op_sequencer: RTL and testbench

- Controller in the Execute stage that owns the shared ALU and the 3-bit flag register.
- Single-cycle ALU ops pass straight through to the ALU.
- MUL is sequenced as a 16-iteration shift-add loop on the same ALU; upstream stages are stalled until it finishes.
- Aborts the in-flight op on pipeline flush.

---
 rtl/exec_op_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_exec_op_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_op_sequencer.sv
// ---------------------------------------------------------------------------
// exec_op_sequencer
//
// Execute-stage controller that owns the shared ALU and the 3-bit flag
// register. Single-cycle ALU instructions pass straight through to the ALU,
// and the ALU's result and flags are registered one cycle later. MUL is run
// as a DATA_W-iteration shift-add loop on the same ALU. Upstream is stalled
// while the loop runs. A flush discards the instruction being issued and
// aborts any multiply that is in flight.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst          in   asynchronous, active-high reset
//   issue_valid  in   an instruction is presented this cycle
//   issue_kind   in   00 NOP, 01 ALU, 10 MUL, 11 reserved (treated as NOP)
//   issue_func   in   ALU control code for an ALU instruction
//   op_a         in   operand 1 / multiplicand
//   op_b         in   operand 2 / multiplier
//   flush        in   kill the issuing instruction and any in-flight op
//   stall        out  upstream must hold its instruction
//   alu_ctrl     out  ALU control code
//   alu_in1      out  ALU operand 1
//   alu_in2      out  ALU operand 2
//   alu_result   in   ALU result
//   alu_flag     in   ALU flags, [0]=Z [1]=N [2]=C
//   res_valid    out  one-cycle pulse, result/flags updated by a finished op
//   result       out  registered result, held between ops
//   flags        out  registered flags, held between ops
//
// State table
//   state      | meaning
//   IDLE       | accepting instructions, ALU driven from the issue operands
//   MUL_RUN    | shift-add multiply loop owns the ALU, upstream stalled
// ---------------------------------------------------------------------------
module exec_op_sequencer #(
    parameter int          DATA_W   = 16,
    parameter logic [2:0]  ADD_CODE = 3'b010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [1:0]        issue_kind,
    input  logic [2:0]        issue_func,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              flush,
    output logic              stall,
    output logic [2:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [2:0]        alu_flag,
    output logic              res_valid,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        flags
);

    localparam int                CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [1:0]        KIND_ALU = 2'b01;
    localparam logic [1:0]        KIND_MUL = 2'b10;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_t;

    state_t            state_q,     state_d;
    logic [DATA_W-1:0] acc_q,       acc_d;
    logic [DATA_W-1:0] mcand_q,     mcand_d;
    logic [DATA_W-1:0] mplier_q,    mplier_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic [DATA_W-1:0] result_q,    result_d;
    logic [2:0]        flags_q,     flags_d;
    logic              res_valid_q, res_valid_d;

    // Flags produced by a completed multiply: carry is meaningless for a
    // truncated product, so it is always reported as clear.
    logic [2:0]        mul_flags;

    assign mul_flags = {1'b0, alu_result[DATA_W-1], (alu_result == '0)};

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            count_q     <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            count_q     <= count_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            res_valid_q <= res_valid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        count_d     = count_q;
        result_d    = result_q;
        flags_d     = flags_q;
        res_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Flush beats issue; NOP and the reserved kind change nothing.
                if (issue_valid && !flush) begin
                    if (issue_kind == KIND_ALU) begin
                        result_d    = alu_result;
                        flags_d     = alu_flag;
                        res_valid_d = 1'b1;
                    end else if (issue_kind == KIND_MUL) begin
                        mcand_d  = op_a;
                        mplier_d = op_b;
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = ST_MUL_RUN;
                    end
                end
            end

            ST_MUL_RUN: begin
                if (flush) begin
                    // Abort wins even on the final iteration; result and
                    // flags keep whatever the last completed op left there.
                    state_d = ST_IDLE;
                end else begin
                    acc_d    = alu_result;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CNT_W'(1);
                    // Fixed iteration count, no early exit on a zero
                    // multiplier. Flags are only published with the
                    // product so they always describe a finished op.
                    if (count_q == CNT_LAST) begin
                        result_d    = alu_result;
                        flags_d     = mul_flags;
                        res_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        stall    = 1'b0;
        alu_ctrl = 3'b000;
        alu_in1  = op_a;
        alu_in2  = op_b;

        if (state_q == ST_MUL_RUN) begin
            stall    = 1'b1;
            alu_ctrl = ADD_CODE;
            alu_in1  = acc_q;
            alu_in2  = mplier_q[0] ? mcand_q : '0;
        end else if (issue_valid && (issue_kind == KIND_ALU)) begin
            alu_ctrl = issue_func;
        end
    end

    assign res_valid = res_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_exec_op_sequencer.sv
module tb_exec_op_sequencer;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          issue_valid = 1'b0;
    logic [1:0]    issue_kind = 2'b00;
    logic [2:0]    issue_func = 3'b000;
    logic [DW-1:0] op_a = '0;
    logic [DW-1:0] op_b = '0;
    logic          flush = 1'b0;
    logic          stall;
    logic [2:0]    alu_ctrl;
    logic [DW-1:0] alu_in1;
    logic [DW-1:0] alu_in2;
    logic [DW-1:0] alu_result;
    logic [2:0]    alu_flag;
    logic          res_valid;
    logic [DW-1:0] result;
    logic [2:0]    flags;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exec_op_sequencer #(.DATA_W(DW), .ADD_CODE(3'b010)) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_kind (issue_kind),
        .issue_func (issue_func),
        .op_a       (op_a),
        .op_b       (op_b),
        .flush      (flush),
        .stall      (stall),
        .alu_ctrl   (alu_ctrl),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_result (alu_result),
        .alu_flag   (alu_flag),
        .res_valid  (res_valid),
        .result     (result),
        .flags      (flags)
    );

    // Simple ALU: returns {C, N, Z, result}.
    function automatic logic [18:0] alu_fn(input logic [2:0] c, input logic [15:0] x,
                                           input logic [15:0] y);
        logic [16:0] s;
        logic [15:0] r;
        logic        cy;
        s  = 17'd0;
        cy = 1'b0;
        case (c)
            3'b000:  r = x & y;
            3'b001:  r = x | y;
            3'b010:  begin s = {1'b0, x} + {1'b0, y}; r = s[15:0]; cy = s[16]; end
            3'b110:  begin s = {1'b0, x} - {1'b0, y}; r = s[15:0]; cy = s[16]; end
            3'b111:  r = (x < y) ? 16'd1 : 16'd0;
            default: r = x ^ y;
        endcase
        return {cy, r[15], (r == 16'd0), r};
    endfunction

    function automatic logic [15:0] mul_lo(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        p = {16'd0, x} * {16'd0, y};
        return p[15:0];
    endfunction

    // Environment ALU attached to the DUT.
    logic [18:0] alu_full;
    assign alu_full   = alu_fn(alu_ctrl, alu_in1, alu_in2);
    assign alu_result = alu_full[15:0];
    assign alu_flag   = alu_full[18:16];

    // Reference ALU evaluation taken straight from the issue inputs.
    logic [18:0] ref_full;
    assign ref_full = alu_fn(issue_func, op_a, op_b);

    // Behavioural model: remaining multiply cycles plus the product.
    int            m_busy   = 0;
    logic          m_valid  = 1'b0;
    logic [DW-1:0] m_result = '0;
    logic [2:0]    m_flags  = '0;
    logic [DW-1:0] m_prod   = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   <= 0;
            m_valid  <= 1'b0;
            m_result <= '0;
            m_flags  <= '0;
            m_prod   <= '0;
        end else begin
            m_valid <= 1'b0;
            if (m_busy != 0) begin
                if (flush) begin
                    m_busy <= 0;
                end else begin
                    m_busy <= m_busy - 1;
                    if (m_busy == 1) begin
                        m_valid  <= 1'b1;
                        m_result <= m_prod;
                        m_flags  <= {1'b0, m_prod[DW-1], (m_prod == '0)};
                    end
                end
            end else if (issue_valid && !flush) begin
                if (issue_kind == 2'b01) begin
                    m_valid  <= 1'b1;
                    m_result <= ref_full[15:0];
                    m_flags  <= ref_full[18:16];
                end else if (issue_kind == 2'b10) begin
                    m_busy <= DW;
                    m_prod <= mul_lo(op_a, op_b);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("stall", {31'd0, stall}, {31'd0, (m_busy != 0)});
        chk("res_valid", {31'd0, res_valid}, {31'd0, m_valid});
        chk("result", {16'd0, result}, {16'd0, m_result});
        chk("flags", {29'd0, flags}, {29'd0, m_flags});
        if (m_busy != 0) begin
            chk("alu_ctrl_mul", {29'd0, alu_ctrl}, 32'd2);
        end else begin
            chk("alu_ctrl_idle", {29'd0, alu_ctrl},
                {29'd0, ((issue_valid && issue_kind == 2'b01) ? issue_func : 3'b000)});
            chk("alu_in1", {16'd0, alu_in1}, {16'd0, op_a});
            chk("alu_in2", {16'd0, alu_in2}, {16'd0, op_b});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [1:0] k, input logic [2:0] f,
                         input logic [15:0] a, input logic [15:0] b);
        issue_valid = v;
        issue_kind  = k;
        issue_func  = f;
        op_a        = a;
        op_b        = b;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 3'b000, 16'd0, 16'd0);
    endtask

    // Issues a MUL and waits (bounded) for its result; lat counts cycles
    // from the issue edge to the res_valid cycle.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, output int lat);
        drive(1'b1, 2'b10, 3'b000, a, b);
        step();
        idle();
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            if (res_valid) begin
                lat = i;
                break;
            end
            step();
        end
        if (lat == 0) chk("mul_timeout", 32'd0, 32'd1);
    endtask

    int lat;
    int stall_cycles;
    int ctrl_bad;
    bit found;

    initial begin
        idle();
        repeat (3) step();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_flags", {29'd0, flags}, 32'd0);
        rst = 1'b0;
        step();

        // ADD 5 + 7
        drive(1'b1, 2'b01, 3'b010, 16'd5, 16'd7);
        step();
        idle();
        chk("add_valid", {31'd0, res_valid}, 32'd1);
        chk("add_result", {16'd0, result}, 32'd12);
        chk("add_flags", {29'd0, flags}, 32'd0);
        chk("add_stall", {31'd0, stall}, 32'd0);

        // AND giving zero, then a NOP
        drive(1'b1, 2'b01, 3'b000, 16'h00F0, 16'h0F00);
        step();
        chk("and_flags", {29'd0, flags}, 32'd1);
        chk("and_result", {16'd0, result}, 32'd0);
        drive(1'b1, 2'b00, 3'b010, 16'h1234, 16'h4321);
        step();
        idle();
        chk("nop_valid", {31'd0, res_valid}, 32'd0);
        chk("nop_flags", {29'd0, flags}, 32'd1);
        chk("nop_result", {16'd0, result}, 32'd0);

        // MUL 3 x 5 with an ADD 1 + 1 held upstream during the stall
        drive(1'b1, 2'b10, 3'b000, 16'd3, 16'd5);
        step();
        drive(1'b1, 2'b01, 3'b010, 16'd1, 16'd1);
        stall_cycles = 0;
        ctrl_bad     = 0;
        found        = 1'b0;
        lat          = 0;
        for (int i = 1; i <= 40; i++) begin
            if (stall) begin
                stall_cycles++;
                if (alu_ctrl != 3'b010) ctrl_bad++;
            end else if (res_valid) begin
                found = 1'b1;
                lat   = i;
                break;
            end
            step();
        end
        chk("mul35_found", {31'd0, found}, 32'd1);
        chk("mul35_stall_cycles", stall_cycles, 32'd16);
        chk("mul35_ctrl", ctrl_bad, 32'd0);
        chk("mul35_latency", lat, 32'd17);
        chk("mul35_result", {16'd0, result}, 32'd15);
        chk("mul35_flags", {29'd0, flags}, 32'd0);
        step();
        idle();
        chk("held_valid", {31'd0, res_valid}, 32'd1);
        chk("held_result", {16'd0, result}, 32'd2);

        // Overflow and negative products
        run_mul(16'h0100, 16'h0100, lat);
        chk("mul_ovf_result", {16'd0, result}, 32'd0);
        chk("mul_ovf_flags", {29'd0, flags}, 32'd1);
        run_mul(16'hFFFF, 16'h0001, lat);
        chk("mul_neg_result", {16'd0, result}, 32'hFFFF);
        chk("mul_neg_flags", {29'd0, flags}, 32'd2);
        step();

        // Flush on the 5th stall cycle
        drive(1'b1, 2'b10, 3'b000, 16'd7, 16'd9);
        step();
        idle();
        repeat (4) step();
        chk("fl5_in_stall", {31'd0, stall}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl5_stall", {31'd0, stall}, 32'd0);
        chk("fl5_valid", {31'd0, res_valid}, 32'd0);
        chk("fl5_result", {16'd0, result}, 32'hFFFF);
        chk("fl5_flags", {29'd0, flags}, 32'd2);
        drive(1'b1, 2'b01, 3'b010, 16'd100, 16'd200);
        step();
        idle();
        chk("post_fl_valid", {31'd0, res_valid}, 32'd1);
        chk("post_fl_result", {16'd0, result}, 32'd300);

        // Flush on the 16th (final) iteration
        drive(1'b1, 2'b10, 3'b000, 16'd7, 16'd9);
        step();
        idle();
        repeat (15) step();
        chk("fl16_in_stall", {31'd0, stall}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl16_stall", {31'd0, stall}, 32'd0);
        chk("fl16_valid", {31'd0, res_valid}, 32'd0);
        chk("fl16_result", {16'd0, result}, 32'd300);
        step();
        chk("fl16_valid_late", {31'd0, res_valid}, 32'd0);

        // Async reset between edges, mid-MUL
        drive(1'b1, 2'b10, 3'b000, 16'd11, 16'd13);
        step();
        idle();
        repeat (3) step();
        #1 rst = 1'b1;
        #1;
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_valid", {31'd0, res_valid}, 32'd0);
        chk("arst_result", {16'd0, result}, 32'd0);
        chk("arst_flags", {29'd0, flags}, 32'd0);
        step();
        rst = 1'b0;
        step();
        run_mul(16'd2, 16'd3, lat);
        chk("post_rst_latency", lat, 32'd17);
        chk("post_rst_result", {16'd0, result}, 32'd6);
        step();

        // Randomized traffic, checked by the per-cycle compare
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom),
                  ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom));
            flush = ($urandom_range(0, 24) == 0);
            step();
        end
        idle();
        flush = 1'b0;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
